// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-port memory between the instruction-fetch path and the
// load/store path. It accepts one transaction at a time and sequences it
// through a request/ready/response handshake on the memory side. The response
// is routed back to whichever requester owns the transaction. Data accesses
// have priority over fetches. A starvation counter forces a pending fetch to
// win after it has lost STARVE_LIMIT arbitrations.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   if_req/if_addr      fetch request, held until if_gnt
//   if_gnt              fetch accepted (combinational, IDLE only)
//   if_rvalid/if_rdata  registered one-cycle fetch response
//   d_req/d_we/d_addr/d_wdata/d_wstrb  data request, held until d_gnt
//   d_gnt               data accepted (combinational, IDLE only)
//   d_rvalid/d_rdata    registered one-cycle load/store response (rdata 0 on stores)
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb  registered memory request
//   mem_ready           memory accepted the request this cycle
//   mem_rvalid/mem_rdata  memory response
module mem_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [XLEN-1:0]   if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [XLEN-1:0]   if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [XLEN-1:0]   d_addr,
    input  logic [XLEN-1:0]   d_wdata,
    input  logic [XLEN/8-1:0] d_wstrb,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [XLEN-1:0]   d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_wstrb,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t          state;
    logic [CW-1:0]   starve_cnt;
    logic            owner_d;     // 1 = transaction belongs to the data path
    logic            fetch_force;
    logic            d_win;
    logic            f_win;

    // A fetch that has lost STARVE_LIMIT times overrides data priority.
    // Grants are suppressed while reset is high so the reset cycle shows no gnt.
    assign fetch_force = if_req && (starve_cnt == CW'(STARVE_LIMIT));
    assign d_win       = !reset && (state == IDLE) && d_req && !fetch_force;
    assign f_win       = !reset && (state == IDLE) && if_req && !d_win;
    assign d_gnt       = d_win;
    assign if_gnt      = f_win;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            owner_d    <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            if_rvalid  <= 1'b0;
            if_rdata   <= '0;
            d_rvalid   <= 1'b0;
            d_rdata    <= '0;
        end else begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (d_win || f_win) begin
                        owner_d   <= d_win;
                        mem_req   <= 1'b1;
                        mem_we    <= d_win && d_we;
                        mem_addr  <= d_win ? d_addr : if_addr;
                        // Fetches carry no store data; drive zero rather than
                        // leaking the previous store's data onto the bus.
                        mem_wdata <= d_win ? d_wdata : '0;
                        mem_wstrb <= (d_win && d_we) ? d_wstrb : '1;
                        state     <= ISSUE;
                    end
                    if (f_win)
                        starve_cnt <= '0;
                    else if (if_req && starve_cnt != CW'(STARVE_LIMIT))
                        starve_cnt <= starve_cnt + 1'b1;
                end
                ISSUE: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        if (owner_d) begin
                            d_rvalid <= 1'b1;
                            d_rdata  <= mem_we ? '0 : mem_rdata;
                        end else begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= mem_rdata;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter (STARVE_LIMIT = 2). A transaction-level model
// tracks the outstanding transaction, the fetch loss count and the expected
// responses; a negedge process compares every DUT output to it each cycle.
// Directed literal checks pin the model to hand-computed values.
module tb_mem_arbiter;

    localparam int XLEN  = 32;
    localparam int LIMIT = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            if_req;
    logic [31:0]     if_addr;
    logic            if_gnt, if_rvalid;
    logic [31:0]     if_rdata;
    logic            d_req, d_we;
    logic [31:0]     d_addr, d_wdata;
    logic [3:0]      d_wstrb;
    logic            d_gnt, d_rvalid;
    logic [31:0]     d_rdata;
    logic            mem_req, mem_we;
    logic [31:0]     mem_addr, mem_wdata;
    logic [3:0]      mem_wstrb;
    logic            mem_ready, mem_rvalid;
    logic [31:0]     mem_rdata;

    mem_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic        started = 1'b0;
    logic        m_busy = 1'b0, m_acc = 1'b0, m_own_d = 1'b0, m_we = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0;
    logic [3:0]  m_wstrb = '0;
    int          m_loss = 0;
    logic        m_irv = 1'b0, m_drv = 1'b0;
    logic [31:0] m_ird = '0, m_drd = '0;
    int          mreq_cnt = 0;
    int          rv_cnt = 0;

    function automatic logic m_fwin();
        return !reset && !m_busy && if_req && (!d_req || m_loss == LIMIT);
    endfunction

    function automatic logic m_dwin();
        return !reset && !m_busy && d_req && !m_fwin();
    endfunction

    always @(posedge clk) begin
        logic fw, dw;
        fw = m_fwin();
        dw = m_dwin();
        started <= 1'b1;
        if (reset) begin
            m_busy <= 1'b0; m_acc <= 1'b0; m_own_d <= 1'b0; m_we <= 1'b0;
            m_addr <= '0; m_wdata <= '0; m_wstrb <= '0; m_loss <= 0;
            m_irv <= 1'b0; m_drv <= 1'b0; m_ird <= '0; m_drd <= '0;
        end else begin
            m_irv <= 1'b0;
            m_drv <= 1'b0;
            if (!m_busy) begin
                if (fw || dw) begin
                    m_busy  <= 1'b1;
                    m_acc   <= 1'b0;
                    m_own_d <= dw;
                    m_we    <= dw && d_we;
                    m_addr  <= dw ? d_addr : if_addr;
                    m_wdata <= dw ? d_wdata : 32'h0;
                    m_wstrb <= (dw && d_we) ? d_wstrb : 4'hF;
                end
                if (fw) m_loss <= 0;
                else if (if_req && m_loss < LIMIT) m_loss <= m_loss + 1;
            end else if (!m_acc) begin
                if (mem_ready) m_acc <= 1'b1;
            end else if (mem_rvalid) begin
                m_busy <= 1'b0;
                if (m_own_d) begin
                    m_drv <= 1'b1;
                    m_drd <= m_we ? 32'h0 : mem_rdata;
                end else begin
                    m_irv <= 1'b1;
                    m_ird <= mem_rdata;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (started) begin
            chk("cmp_if_gnt",    if_gnt,    m_fwin());
            chk("cmp_d_gnt",     d_gnt,     m_dwin());
            chk("cmp_mem_req",   mem_req,   m_busy && !m_acc);
            chk("cmp_mem_we",    mem_we,    m_we);
            chk("cmp_mem_addr",  mem_addr,  m_addr);
            chk("cmp_mem_wdata", mem_wdata, m_wdata);
            chk("cmp_mem_wstrb", mem_wstrb, m_wstrb);
            chk("cmp_if_rvalid", if_rvalid, m_irv);
            chk("cmp_d_rvalid",  d_rvalid,  m_drv);
            chk("cmp_if_rdata",  if_rdata,  m_ird);
            chk("cmp_d_rdata",   d_rdata,   m_drd);
            if (mem_req) mreq_cnt <= mreq_cnt + 1;
            if (if_rvalid || d_rvalid) rv_cnt <= rv_cnt + 1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Called at the start of ISSUE cycle 1; returns at the start of the
    // cycle in which the owner's rvalid is expected.
    task automatic mem_serve(input int rdy_wait, input int rsp_wait, input logic [31:0] rd);
        repeat (rdy_wait) begin
            mem_ready = 1'b0;
            step();
        end
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        repeat (rsp_wait - 1) step();
        mem_rvalid = 1'b1;
        mem_rdata  = rd;
        step();
        mem_rvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    logic [3:0] gd, gi;
    int         mr0, rv0;

    initial begin
        reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_wstrb = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) step();
        @(negedge clk);
        chk("reset_outputs", {30'd0, if_gnt, d_gnt} | {26'd0, if_rvalid, d_rvalid, mem_req, mem_we, 2'b00}, 32'h0);
        chk("reset_mem_addr", mem_addr, 32'h0);
        step();
        reset = 1'b0;
        step();

        // Fetch only, zero-wait memory
        if_req = 1'b1; if_addr = 32'h10;
        @(negedge clk); chk("fetch_gnt_c0", if_gnt, 1); chk("fetch_no_dgnt", d_gnt, 0);
        step(); if_req = 1'b0; mem_ready = 1'b1;
        @(negedge clk); chk("fetch_mem_req_c1", mem_req, 1); chk("fetch_mem_addr", mem_addr, 32'h10);
        chk("fetch_wstrb", mem_wstrb, 4'hF);
        step(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h93;
        @(negedge clk); chk("fetch_mem_req_c2", mem_req, 0);
        step(); mem_rvalid = 1'b0;
        @(negedge clk); chk("fetch_rvalid_c3", if_rvalid, 1); chk("fetch_rdata", if_rdata, 32'h93);
        chk("fetch_no_drvalid", d_rvalid, 0);
        step();

        // Simultaneous requests: store wins, fetch at the next IDLE
        if_req = 1'b1; if_addr = 32'h20;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'h3;
        @(negedge clk); chk("sim_d_first", d_gnt, 1); chk("sim_if_waits", if_gnt, 0);
        step(); d_req = 1'b0; d_we = 1'b0;
        mem_serve(0, 1, 32'h1111_1111);
        @(negedge clk);
        chk("sim_d_rvalid", d_rvalid, 1); chk("sim_store_rdata", d_rdata, 32'h0);
        chk("sim_mem_we", mem_we, 1); chk("sim_mem_wstrb", mem_wstrb, 4'h3);
        chk("sim_mem_wdata", mem_wdata, 32'hDEAD_BEEF); chk("sim_if_gnt_next", if_gnt, 1);
        step(); if_req = 1'b0;
        mem_serve(0, 1, 32'h13);
        @(negedge clk); chk("sim_if_rdata", if_rdata, 32'h13);
        step();

        // Starvation with limit 2: d, d, fetch, then d again (counter cleared)
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; if_req = 1'b1; if_addr = 32'h40;
        for (int g = 0; g < 4; g++) begin
            @(negedge clk);
            gd[g] = d_gnt;
            gi[g] = if_gnt;
            step();
            if (g == 3) begin d_req = 1'b0; if_req = 1'b0; end
            mem_serve(0, 1, 32'h500 + g);
        end
        chk("starve_d_grants", {28'd0, gd}, 32'h0000_000B);
        chk("starve_if_grants", {28'd0, gi}, 32'h0000_0004);
        @(negedge clk); chk("starve_last_load", d_rdata, 32'h503);
        step();

        // Backpressure: ready after 5 low cycles, response 3 cycles later
        if_req = 1'b1; if_addr = 32'h80;
        mr0 = mreq_cnt; rv0 = rv_cnt;
        @(negedge clk); chk("bp_gnt", if_gnt, 1);
        step(); if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        mem_serve(5, 3, 32'hCAFE_0001);
        @(negedge clk);
        chk("bp_if_rvalid", if_rvalid, 1); chk("bp_if_rdata", if_rdata, 32'hCAFE_0001);
        chk("bp_d_gnt_after", d_gnt, 1);
        step();
        chk("bp_issue_cycles", mreq_cnt - mr0, 6);
        chk("bp_one_rvalid", rv_cnt - rv0, 1);
        d_req = 1'b0;
        mem_serve(0, 1, 32'h55);
        @(negedge clk); chk("bp_d_rdata", d_rdata, 32'h55);
        step();

        // Stray response in IDLE is ignored
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD;
        step(); mem_rvalid = 1'b0;
        @(negedge clk); chk("stray_no_rvalid", {31'd0, if_rvalid | d_rvalid}, 0);
        step();
        if_req = 1'b1; if_addr = 32'h90;
        @(negedge clk); chk("stray_then_gnt", if_gnt, 1);
        step(); if_req = 1'b0;
        mem_serve(0, 2, 32'h99);
        @(negedge clk); chk("stray_then_rdata", if_rdata, 32'h99);
        step();

        // Reset while in WAIT, late response dropped
        if_req = 1'b1; if_addr = 32'hA0;
        @(negedge clk); chk("rst_gnt", if_gnt, 1);
        step(); if_req = 1'b0; mem_ready = 1'b1;
        step(); mem_ready = 1'b0; reset = 1'b1;
        step(); reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h77;
        @(negedge clk);
        chk("rst_ctl_zero", {26'd0, if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req, mem_we}, 0);
        chk("rst_if_rdata", if_rdata, 0); chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wstrb", mem_wstrb, 0);
        step(); mem_rvalid = 1'b0;
        @(negedge clk); chk("rst_no_rvalid", {31'd0, if_rvalid | d_rvalid}, 0);
        step();
        if_req = 1'b1; if_addr = 32'hB0;
        @(negedge clk); chk("rst_resume_gnt", if_gnt, 1);
        step(); if_req = 1'b0;
        mem_serve(1, 1, 32'hB1);
        @(negedge clk); chk("rst_resume_rdata", if_rdata, 32'hB1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
